// File: rtl/mod3_rr_checker.sv
// mod3_rr_checker: round-robin shared serial divisibility-by-3 checker with tagged responses
module mod3_rr_checker #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(NREQ) > 1 ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [1:0]            rsp_rem,
  output logic                  rsp_div,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [IDW-1:0]   gnt_id;
  logic             found;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [1:0]       rem;
  logic [1:0]       rem_nxt;
  logic             b;
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    return IDW'(j >= NREQ ? j - NREQ : j);
  endfunction
  assign b         = sr[WIDTH-1];
  assign rem_nxt   = rem == 2'd0 ? {1'b0, b} : rem == 2'd1 ? (b ? 2'd0 : 2'd2) : (b ? 2'd2 : 2'd1);
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  assign req_ready = (state == IDLE && found) ? NREQ'(1) << gnt_id : '0;
  // first valid requester at or after ptr, wrapping
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[wrap_idx(ptr, k)]) begin
        found  = 1'b1;
        gnt_id = wrap_idx(ptr, k);
      end
    end
  end
  // controller: capture on grant, fold one bit per cycle MSB-first, hold result until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      id      <= '0;
      sr      <= '0;
      cnt     <= '0;
      rem     <= '0;
      rsp_id  <= '0;
      rsp_rem <= '0;
      rsp_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sr    <= req_data[gnt_id*WIDTH +: WIDTH];
            id    <= gnt_id;
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            ptr   <= wrap_idx(gnt_id, 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr << 1;
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= RESP;
            rsp_id  <= id;
            rsp_rem <= rem_nxt;
            rsp_div <= rem_nxt == 2'd0;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod3_rr_checker.sv
// tb_mod3_rr_checker: directed table-driven bench for the shared mod-3 checker
module tb_mod3_rr_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_rem;
  logic        rsp_div;
  logic        busy;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int         id;
    logic [7:0] d;
    int         er;
  } vec_t;
  vec_t tbl[9];
  int   er_rr[4] = '{1, 2, 0, 1};
  always #5 clk = ~clk;
  mod3_rr_checker #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_rem(rsp_rem), .rsp_div(rsp_div), .busy(busy)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    chk("drain idle", int'(busy), 0);
  endtask
  task automatic do_word(input int id, input logic [7:0] d, input logic [7:0] d2, input int er, input string nm);
    int n;
    req_data[id*8 +: 8] = d;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      tick;
      n++;
    end
    chk({nm, " grant"}, int'(req_ready), 1 << id);
    tick;
    req_valid[id] = 1'b0;
    req_data[id*8 +: 8] = d2;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
    chk({nm, " latency"}, n, 8);
    chk({nm, " id"}, int'(rsp_id), id);
    chk({nm, " rem"}, int'(rsp_rem), er);
    chk({nm, " div"}, int'(rsp_div), int'(er == 0));
    tick;
    chk({nm, " consumed"}, int'(rsp_valid), 0);
  endtask
  initial begin
    int n, got, multi, unstable, rdy, seen;
    logic [1:0] sid, srem;
    logic sdiv;
    tbl[0] = '{0, 8'h00, 0};
    tbl[1] = '{0, 8'h07, 1};
    tbl[2] = '{0, 8'h08, 2};
    tbl[3] = '{0, 8'hFF, 0};
    tbl[4] = '{0, 8'h80, 2};
    tbl[5] = '{0, 8'h55, 1};
    tbl[6] = '{3, 8'h2A, 0};
    tbl[7] = '{1, 8'h01, 1};
    tbl[8] = '{2, 8'h7F, 1};
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_id", int'(rsp_id), 0);
    chk("reset rsp_rem", int'(rsp_rem), 0);
    chk("reset rsp_div", int'(rsp_div), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset req_ready", int'(req_ready), 0);
    req_data[16 +: 8] = 8'h06;
    req_valid = 4'b0100;
    #1;
    chk("t1 grant", int'(req_ready), 4);
    tick;
    n = 0;
    while (n < 20 && req_ready == 4'b0000) begin
      tick;
      n++;
      if (rsp_valid) begin
        chk("t1 latency", n, 8);
        chk("t1 id", int'(rsp_id), 2);
        chk("t1 rem", int'(rsp_rem), 0);
        chk("t1 div", int'(rsp_div), 1);
      end
    end
    chk("t1 next grant cycles", n, 9);
    req_valid = '0;
    tick;
    chk("t1 idle", int'(busy), 0);
    for (int i = 0; i < 9; i++)
      do_word(tbl[i].id, tbl[i].d, tbl[i].d, tbl[i].er, $sformatf("vec%0d", i));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    got = 0;
    multi = 0;
    n = 0;
    while (got < 6 && n < 200) begin
      tick;
      n++;
      if ($countones(req_ready) > 1) multi++;
      if (rsp_valid) begin
        chk($sformatf("rr%0d id", got), int'(rsp_id), got % 4);
        chk($sformatf("rr%0d rem", got), int'(rsp_rem), er_rr[got % 4]);
        got++;
      end
    end
    chk("rr count", got, 6);
    chk("rr onehot", multi, 0);
    req_valid = '0;
    drain;
    req_data[24 +: 8] = 8'h0A;
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 30) begin
      tick;
      n++;
    end
    req_valid = 4'b0001;
    sid = rsp_id;
    srem = rsp_rem;
    sdiv = rsp_div;
    chk("bp id", int'(sid), 3);
    chk("bp rem", int'(srem), 1);
    chk("bp div", int'(sdiv), 0);
    unstable = 0;
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (rsp_valid !== 1'b1 || rsp_id !== sid || rsp_rem !== srem || rsp_div !== sdiv) unstable++;
      if (req_ready != 4'b0000) rdy++;
    end
    chk("bp stable", unstable, 0);
    chk("bp req_ready low", rdy, 0);
    rsp_ready = 1'b1;
    req_valid = '0;
    tick;
    chk("bp consumed", int'(rsp_valid), 0);
    tick;
    chk("bp single", int'(rsp_valid), 0);
    chk("bp idle", int'(busy), 0);
    do_word(1, 8'h03, 8'h04, 0, "stab");
    req_data[16 +: 8] = 8'hFF;
    req_valid = 4'b0100;
    #1;
    chk("rst grant", int'(req_ready), 4);
    tick;
    req_valid = '0;
    repeat (4) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst busy", int'(busy), 0);
    chk("rst rsp_valid", int'(rsp_valid), 0);
    req_valid = 4'hF;
    #1;
    chk("rst ptr", int'(req_ready), 1);
    req_valid = '0;
    seen = 0;
    repeat (12) begin
      tick;
      if (rsp_valid) seen++;
    end
    chk("rst no rsp", seen, 0);
    do_word(0, 8'h0B, 8'h0B, 2, "post");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod3_rr_checker.md
# mod3_rr_checker

Shared divisibility-by-3 service for several requesters. Each requester submits a parallel WIDTH-bit word through a valid/ready port. A round-robin arbiter grants one word at a time. The word is fed MSB-first through an internal serial remainder-mod-3 state machine, one bit per clock, and the result is returned on a single response port tagged with the requester index.

## Interface
- NREQ, 4: number of requesters; legal range ≥ 2.
- WIDTH, 8: bits per word; legal range ≥ 1.
- IDW, max(1, $clog2(NREQ)): width of the requester index (derived, not overridden).
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  bit i is high when requester i has a word pending.
- req_data  in  NREQ*WIDTH  word of requester i in bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot or zero; a transfer on port i occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  a result is presented.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester whose word produced the result.
- rsp_rem  out  2  word mod 3, with values 0..2.
- rsp_div  out  1  high when rsp_rem == 0.
- busy  out  1  high in the SHIFT and RESP states.

## Operation
The controller has three states, IDLE, SHIFT and RESP; reset forces IDLE.

**IDLE**
- The arbiter searches req_valid starting at index ptr, then ptr+1, and so on, wrapping modulo NREQ.
- The first set bit g is granted. req_ready[g] is driven high combinationally in the same cycle; all other req_ready bits are 0.
- If no req_valid bit is set, req_ready = 0 and the controller stays in IDLE.
- On the transfer edge:
  - shift register ← req_data[g]
  - id ← g
  - rem ← 0
  - bit counter ← WIDTH
  - ptr ← (g+1) mod NREQ
  - state → SHIFT

**SHIFT**
- req_ready = 0.
- On each edge, with b = shift register MSB, rem updates as rem ← (2*rem + b) mod 3. Transitions, written (rem, b) → rem: (0,0)→0, (0,1)→1, (1,0)→2, (1,1)→0, (2,0)→1, (2,1)→2.
- On the same edge the shift register shifts left by one and the counter decrements.
- On the edge where the counter goes from 1 to 0, state → RESP.

**RESP**
- rsp_valid = 1; rsp_id, rsp_rem and rsp_div are driven from the registered values. req_ready = 0.
- All response outputs are held stable while rsp_ready = 0.
- On the edge where rsp_valid and rsp_ready are both high, state → IDLE.

**General rules**
- req_data is sampled only on the transfer edge. Later changes to req_data or req_valid have no effect on the word in flight.
- When not in RESP: rsp_valid = 0, and rsp_id, rsp_rem and rsp_div hold their last values (0 after reset).
- Arithmetic: rem is always 2 bits and never holds 3. A WIDTH of 1 is legal and gives rem = b.
- Boundary: if several requesters become valid while a word is in flight, the next IDLE arbitration uses the updated ptr, so a requester that was just served cannot be granted again while any other requester is valid.

**Reset values**
- state IDLE, ptr 0
- rsp_valid 0, rsp_id 0, rsp_rem 0, rsp_div 0
- busy 0, req_ready 0

**Reset mid-operation**
- Reset during SHIFT or RESP discards the in-flight word; no response is produced.
- A requester that was already granted is not re-granted automatically. It must still be holding req_valid high to be re-arbitrated after reset.

## Timing
- Transfer edge E0. Bits are consumed on edges E1..E_WIDTH.
- rsp_valid rises in the cycle after E_WIDTH, i.e. WIDTH clock edges after the transfer.
- A response handshake at edge R returns the controller to IDLE. The earliest next transfer is edge R+1, since req_ready is evaluated in the IDLE cycle after R.
- Minimum period per word with rsp_ready tied high is WIDTH+2 cycles: 1 cycle IDLE, WIDTH cycles SHIFT, 1 cycle RESP.
- busy rises in the cycle after E0 and falls in the cycle after R.

## Test plan
- Single word, WIDTH=8, NREQ=4: requester 2 sends 0x06 with rsp_ready=1 → req_ready[2] high in the transfer cycle; rsp_valid 8 edges later with rsp_id=2, rsp_rem=0, rsp_div=1; next transfer no earlier than 10 cycles after the first.
- Remainder sweep on requester 0: words 0x00, 0x07, 0x08, 0xFF, 0x80, 0x55 → rsp_rem 0, 1, 2, 0, 2, 1 respectively, with rsp_div high only for 0x00 and 0xFF.
- Round-robin: all four req_valid held high from reset with distinct words → rsp_id sequence 0, 1, 2, 3, 0, 1; req_ready never has more than one bit set.
- Backpressure: rsp_ready held low for 5 cycles once rsp_valid rises → rsp_valid, rsp_id, rsp_rem and rsp_div stable for all 5 cycles; req_ready stays 0; a single response is consumed once rsp_ready rises.
- Input stability: req_data[1] changes from 0x03 to 0x04 in the cycle after transfer → result is still rsp_rem=0 (the value sampled at transfer).
- Reset mid-SHIFT: reset asserted for one cycle at bit 4 of 8 → no rsp_valid; ptr = 0, busy = 0 after reset; a new word 0x0B then yields rsp_rem=2 with normal latency.
